// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 pipeline: fetch FSM states, reset PC
// and the branch opcodes decoded by the EX/MEM redirect logic.
package mips32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] BNEQZ = 6'b001101;

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO used as the prefetch queue; the head word is presented
// combinationally and flush returns it to the empty state in one cycle.
module mips32_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full queue is only accepted when a pop frees the head slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction fetch unit: single-outstanding imem request FSM feeding a
// prefetch queue that drains into ID, with branch redirect and halt.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_ir,
  output logic [31:0]              id_npc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fpc;
  logic [31:0]   fpc_next;
  logic [31:0]   fpc_inc;
  logic          req_next;
  logic [AW-1:0] addr_next;
  logic          push;
  logic          pop;
  logic          space;
  logic [CW:0]   cnt_after;
  logic [63:0]   fifo_rdata;

  assign fpc_inc  = fpc + 32'd1;
  assign id_valid = (q_count != '0);
  assign id_ir    = fifo_rdata[63:32];
  assign id_npc   = fifo_rdata[31:0];

  // A redirect flushes the queue, so neither the pop nor a returning word counts.
  always_comb begin
    push      = (state == WAIT) && imem_ack && !redirect;
    pop       = id_valid && id_ready && !redirect;
    cnt_after = {1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop);
    space     = (cnt_after < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_next;
      fpc       <= fpc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    if (redirect) begin
      fpc_next = redirect_pc;
      if ((state == IDLE) || imem_ack) begin
        state_next = halt ? IDLE : WAIT;
      end else begin
        state_next = FLUSH;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (!halt && space) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fpc_next   = fpc_inc;
            state_next = (!halt && space) ? WAIT : IDLE;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            state_next = halt ? IDLE : WAIT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The address only moves when a fresh request starts; an outstanding one,
  // including a stale one being flushed, keeps its original address.
  always_comb begin
    req_next  = (state_next != IDLE);
    addr_next = imem_addr;
    if ((state_next == WAIT) && ((state == IDLE) || imem_ack)) begin
      addr_next = fpc_next[AW-1:0];
    end
  end

  mips32_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_queue (
    .clk1  (clk1),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_rdata, fpc_inc}),
    .rdata (fifo_rdata),
    .count (q_count)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for the fetch queue: a latency-programmable instruction
// memory responder plus hand-computed expectations for each scenario.
module tb_mips32_fetch_queue;

  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [31:0]   id_ir;
  logic [31:0]   id_npc;
  logic [2:0]    q_count;

  logic [31:0]   mem [1024];
  int            lat = 0;
  int            wcnt = 0;
  int            vectors = 0;
  int            miscompares = 0;

  mips32_fetch_queue #(
    .DEPTH    (4),
    .AW       (AW),
    .RESET_PC (32'h0)
  ) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_npc      (id_npc),
    .q_count     (q_count)
  );

  always #5 clk1 = ~clk1;

  // Memory answers a request after 'lat' extra cycles of waiting.
  always @(negedge clk1) begin
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wcnt       = 0;
      end else begin
        imem_ack = 1'b0;
        wcnt     = wcnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors = vectors + 1;
    if (observed !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic hlt, input logic rdr,
                               input logic [31:0] rpc);
    id_ready    = rdy;
    halt        = hlt;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk1);
    #1;
  endtask

  task automatic doReset(input int l, input logic rdy);
    rst_n    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    id_ready = rdy;
    lat      = l;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_ir [4];
    exp_ir = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC000_0000 | 32'(i);
    end

    // Reset values while rst_n is held low
    @(posedge clk1);
    #1;
    checkOutput("rst_req",   64'(imem_req),  64'd0);
    checkOutput("rst_addr",  64'(imem_addr), 64'd0);
    checkOutput("rst_valid", 64'(id_valid),  64'd0);
    checkOutput("rst_count", 64'(q_count),   64'd0);
    checkOutput("rst_ir",    64'(id_ir),     64'd0);
    checkOutput("rst_npc",   64'(id_npc),    64'd0);

    // Zero-wait streaming, decode always ready
    doReset(0, 1'b1);
    checkOutput("s1_req0", 64'(imem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s1_req1",   64'(imem_req),  64'd1);
    checkOutput("s1_addr1",  64'(imem_addr), 64'd0);
    checkOutput("s1_valid1", 64'(id_valid),  64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s1_ir",  64'(id_ir),  64'(exp_ir[i]));
      checkOutput("s1_npc", 64'(id_npc), 64'(i + 1));
    end

    // Decode stalled: queue fills to 4, then resumes in order at address 4
    doReset(0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_full",  64'(q_count),  64'd4);
    checkOutput("s2_req0",  64'(imem_req), 64'd0);
    checkOutput("s2_head0", 64'(id_ir),    64'hC000_0000);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_stay",  64'(q_count),  64'd4);
    checkOutput("s2_idle",  64'(imem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_reqr",  64'(imem_req),  64'd1);
    checkOutput("s2_addr4", 64'(imem_addr), 64'd4);
    checkOutput("s2_cnt3",  64'(q_count),   64'd3);
    checkOutput("s2_head1", 64'(id_ir),     64'hC000_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_head2", 64'(id_ir), 64'hC000_0002);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_head3", 64'(id_ir), 64'hC000_0003);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_head4", 64'(id_ir),  64'hC000_0004);
    checkOutput("s2_npc5",  64'(id_npc), 64'd5);

    // Slow memory, redirect to 20 while the first request is outstanding
    doReset(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd20);
    checkOutput("s3_req_kept",  64'(imem_req),  64'd1);
    checkOutput("s3_addr_kept", 64'(imem_addr), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_addr_hold", 64'(imem_addr), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_addr20",  64'(imem_addr), 64'd20);
    checkOutput("s3_nostale", 64'(id_valid),  64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_wait", 64'(id_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_valid", 64'(id_valid), 64'd1);
    checkOutput("s3_ir",    64'(id_ir),    64'hC000_0014);
    checkOutput("s3_npc",   64'(id_npc),   64'd21);

    // Redirect with a pop on a full queue, then redirect coincident with ack
    doReset(0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd100);
    checkOutput("s4_cnt0",    64'(q_count),   64'd0);
    checkOutput("s4_valid0",  64'(id_valid),  64'd0);
    checkOutput("s4_addr100", 64'(imem_addr), 64'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_ir100",  64'(id_ir),  64'hC000_0064);
    checkOutput("s4_npc101", 64'(id_npc), 64'd101);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd200);
    checkOutput("s4_flush",   64'(q_count),   64'd0);
    checkOutput("s4_addr200", 64'(imem_addr), 64'd200);
    checkOutput("s4_req",     64'(imem_req),  64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_ir200",  64'(id_ir),   64'hC000_00C8);
    checkOutput("s4_npc201", 64'(id_npc),  64'd201);
    checkOutput("s4_cnt1",   64'(q_count), 64'd1);

    // Halt with a request outstanding
    doReset(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_req_held", 64'(imem_req), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_req_drop", 64'(imem_req), 64'd0);
    checkOutput("s5_cnt1",     64'(q_count),  64'd1);
    checkOutput("s5_ir",       64'(id_ir),    64'hC000_0000);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_no_req", 64'(imem_req), 64'd0);
    checkOutput("s5_cnt_kept", 64'(q_count), 64'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("s5_drained", 64'(q_count),  64'd0);
    checkOutput("s5_valid0",  64'(id_valid), 64'd0);
    checkOutput("s5_idle",    64'(imem_req), 64'd0);

    // Asynchronous reset mid-WAIT, then address and PC wrap-around
    doReset(0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_pre_addr", 64'(imem_addr), 64'd2);
    checkOutput("s6_pre_cnt",  64'(q_count),   64'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_req",   64'(imem_req),  64'd0);
    checkOutput("s6_rst_addr",  64'(imem_addr), 64'd0);
    checkOutput("s6_rst_cnt",   64'(q_count),   64'd0);
    checkOutput("s6_rst_valid", 64'(id_valid),  64'd0);
    checkOutput("s6_rst_ir",    64'(id_ir),     64'd0);
    checkOutput("s6_rst_npc",   64'(id_npc),    64'd0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_restart_req",  64'(imem_req),  64'd1);
    checkOutput("s6_restart_addr", 64'(imem_addr), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd1023);
    checkOutput("s6_addr1023", 64'(imem_addr), 64'd1023);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_ir1023",  64'(id_ir),     64'hC000_03FF);
    checkOutput("s6_npc1024", 64'(id_npc),    64'd1024);
    checkOutput("s6_addr0",   64'(imem_addr), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("s6_addr_top", 64'(imem_addr), 64'd1023);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_npc_wrap",  64'(id_npc),    64'd0);
    checkOutput("s6_addr_wrap", 64'(imem_addr), 64'd0);
    checkOutput("s6_valid",     64'(id_valid),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
